// File: rtl/pipe_pkg.sv
// Shared state encoding for handshaked pipeline stages.
// Encoding 2'd3 is illegal; stages that use this type recover from it to PS_EMPTY.
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_BUSY  = 2'd1,
        PS_FULL  = 2'd2
    } ps_state_e;

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter for the stall statistics of pipe_stage_skid.
// Priority: rst, then clr, then inc. The count holds at its all-ones value and does not wrap.
module pipe_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry skid-buffer pipeline stage: in_ready is decoded from the state register only.
// With PIPE_STAGE_FLUSH_EN defined, a flush port is added that empties the stage.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUM_CH*WIDTH-1:0] out_data,
    input  logic                    cnt_clr,
`ifdef PIPE_STAGE_FLUSH_EN
    input  logic                    flush,
`endif
    output logic [CNT_W-1:0]        stall_cnt
);

    localparam int unsigned DW = NUM_CH * WIDTH;

    ps_state_e         state;
    ps_state_e         state_next;
    logic [DW-1:0]     main_q;
    logic [DW-1:0]     skid_q;
    logic              in_xfer;
    logic              out_xfer;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid;

    assign out_valid = (state != PS_EMPTY);
    assign in_ready  = (state != PS_FULL);
    assign out_data  = main_q;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;

        case (state)
            PS_EMPTY: begin
                if (in_xfer) begin
                    load_main_in = 1'b1;
                    state_next   = PS_BUSY;
                end
            end
            PS_BUSY: begin
                if (in_xfer && out_xfer) begin
                    load_main_in = 1'b1;
                end else if (in_xfer) begin
                    load_skid  = 1'b1;
                    state_next = PS_FULL;
                end else if (out_xfer) begin
                    state_next = PS_EMPTY;
                end
            end
            PS_FULL: begin
                if (out_xfer) begin
                    load_main_skid = 1'b1;
                    state_next     = PS_BUSY;
                end
            end
            default: state_next = PS_EMPTY;
        endcase

`ifdef PIPE_STAGE_FLUSH_EN
        // Flush overrides the handshake: any beat accepted this cycle is dropped.
        if (flush) begin
            state_next     = PS_EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= PS_EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state <= state_next;
            if (load_main_in) begin
                main_q <= in_data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_valid & ~out_ready),
        .clr   (cnt_clr),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid (WIDTH=32, NUM_CH=2, CNT_W=4).
// Flush checks are built only when PIPE_STAGE_FLUSH_EN is defined.
module tb_pipe_stage_skid;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned NUM_CH = 2;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DW     = NUM_CH * WIDTH;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic              cnt_clr;
    logic [CNT_W-1:0]  stall_cnt;
`ifdef PIPE_STAGE_FLUSH_EN
    logic              flush;
`endif

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .WIDTH  (WIDTH),
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cnt_clr   (cnt_clr),
`ifdef PIPE_STAGE_FLUSH_EN
        .flush     (flush),
`endif
        .stall_cnt (stall_cnt)
    );

    // Beat n: channel 1 = 32'hAAAA0000 | n, channel 0 = n.
    function automatic logic [DW-1:0] beat(input int unsigned n);
        logic [31:0] lo;
        lo = 32'(n);
        return {32'hAAAA0000 | lo, lo};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; cnt_clr = 1'b0;
`ifdef PIPE_STAGE_FLUSH_EN
        flush = 1'b0;
`endif
        tick();
        rst = 1'b0;
        check("rst_out_valid", DW'(out_valid), DW'(1'b0));
        check("rst_in_ready",  DW'(in_ready),  DW'(1'b1));
        check("rst_out_data",  out_data,       '0);
        check("rst_stall_cnt", DW'(stall_cnt), '0);

        // Single beat, one-cycle latency
        in_valid = 1'b1; in_data = beat(1); out_ready = 1'b1;
        tick();
        check("single_valid", DW'(out_valid), DW'(1'b1));
        check("single_data",  out_data,       {32'hAAAA0001, 32'h00000001});
        check("single_ready", DW'(in_ready),  DW'(1'b1));
        in_valid = 1'b0;
        tick();
        check("single_drained", DW'(out_valid), DW'(1'b0));

        // Streaming 8 beats with no bubbles
        for (int unsigned i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = beat(i);
            tick();
            check($sformatf("stream_valid_%0d", i), DW'(out_valid), DW'(1'b1));
            check($sformatf("stream_data_%0d", i),  out_data,       beat(i));
            check($sformatf("stream_ready_%0d", i), DW'(in_ready),  DW'(1'b1));
        end
        in_valid = 1'b0;
        tick();
        check("stream_end", DW'(out_valid), DW'(1'b0));

        // Backpressure: fill both entries, then drain in order
        out_ready = 1'b0; in_valid = 1'b1; in_data = beat(1);
        tick();
        check("bp1_ready", DW'(in_ready), DW'(1'b1));
        check("bp1_data",  out_data,      beat(1));
        in_data = beat(2);
        tick();
        check("bp2_ready", DW'(in_ready),  DW'(1'b0));
        check("bp2_data",  out_data,       beat(1));
        check("bp2_cnt",   DW'(stall_cnt), DW'(4'd1));
        in_valid = 1'b0; in_data = beat(7);
        tick();
        check("bp_hold_data", out_data, beat(1));
        check("bp_hold_cnt",  DW'(stall_cnt), DW'(4'd2));
        out_ready = 1'b1;
        tick();
        check("drain1_data",  out_data,       beat(2));
        check("drain1_valid", DW'(out_valid), DW'(1'b1));
        check("drain1_ready", DW'(in_ready),  DW'(1'b1));
        tick();
        check("drain2_valid", DW'(out_valid), DW'(1'b0));

        // Stall counter saturation and clear
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_cnt", DW'(stall_cnt), '0);
        out_ready = 1'b0; in_valid = 1'b1; in_data = beat(3);
        tick();
        in_valid = 1'b0;
        check("cnt_start", DW'(stall_cnt), '0);
        repeat (5) tick();
        check("cnt_5", DW'(stall_cnt), DW'(4'd5));
        repeat (15) tick();
        check("cnt_sat",      DW'(stall_cnt), DW'(4'd15));
        check("cnt_sat_data", out_data,       beat(3));
        cnt_clr = 1'b1;
        tick();
        check("cnt_clr_wins", DW'(stall_cnt), '0);
        cnt_clr = 1'b0;
        tick();
        check("cnt_restart", DW'(stall_cnt), DW'(4'd1));

        // Reset while FULL
        in_valid = 1'b1; in_data = beat(4);
        tick();
        in_valid = 1'b0;
        check("full_ready", DW'(in_ready), DW'(1'b0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstfull_valid", DW'(out_valid), DW'(1'b0));
        check("rstfull_ready", DW'(in_ready),  DW'(1'b1));
        check("rstfull_data",  out_data,       '0);
        check("rstfull_cnt",   DW'(stall_cnt), '0);
        out_ready = 1'b1;
        tick();
        check("rstfull_empty", DW'(out_valid), DW'(1'b0));

`ifdef PIPE_STAGE_FLUSH_EN
        // Flush while FULL discards everything, including the concurrent beat
        out_ready = 1'b0; in_valid = 1'b1; in_data = beat(5);
        tick();
        in_data = beat(6);
        tick();
        check("fl_full", DW'(in_ready), DW'(1'b0));
        flush = 1'b1; in_data = beat(7);
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("fl_valid", DW'(out_valid), DW'(1'b0));
        check("fl_ready", DW'(in_ready),  DW'(1'b1));
        repeat (3) begin
            tick();
            check("fl_no_beat", DW'(out_valid), DW'(1'b0));
        end
        in_valid = 1'b1; in_data = beat(9);
        tick();
        in_valid = 1'b0;
        check("fl_b9_valid", DW'(out_valid), DW'(1'b1));
        check("fl_b9_data",  out_data,       beat(9));
        tick();
        check("fl_b9_alone", DW'(out_valid), DW'(1'b0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
